// File: rtl/jk_exc_pkg.sv
// Purpose : shared types and helpers for the JK excitation driver.
// Latency : n/a (types, constants and pure functions only).
// Backpr. : n/a.
// Contents: FSM state enum, counter-width helper, per-bit JK excitation function.
package jk_exc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2
  } jk_state_e;

  // Counters are never narrower than one bit, even when they only count to 0.
  localparam int CNT_MIN_W = 1;

  // Width of a counter that must hold values 0..n.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < CNT_MIN_W) ? CNT_MIN_W : w;
  endfunction

  // Minimal JK excitation with don't-cares resolved to 0: returns {j, k}.
  // Hold cases (0->0, 1->1) give j=k=0; the toggle code j=k=1 never appears.
  function automatic logic [1:0] jk_excite(input logic tgt, input logic q);
    return {tgt & ~q, ~tgt & q};
  endfunction

endpackage

// File: rtl/jk_exc_encode.sv
// Purpose : WIDTH-bit combinational JK excitation encoder (target vs present Q).
// Latency : 0 cycles, purely combinational.
// Backpr. : none; output follows inputs.
// Ports   : tgt/q in (WIDTH), j/k out (WIDTH).
module jk_exc_encode
  import jk_exc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {j[i], k[i]} = jk_excite(tgt[i], q[i]);
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Purpose : drives J/K excitation into a JK flip-flop bank, verifies Q, retries on mismatch.
// Latency : 2+SETTLE cycles accept-to-done; each retry adds 1+SETTLE cycles.
// Backpr. : in_ready only while idle; in_valid outside idle is ignored.
// Ports   : C/RESETn clock and async active-low reset; in_valid/in_ready/in_target request;
//           q_fb bank feedback; j_out/k_out excitation; busy, done/err pulses, err_bits.
module jk_excitation_driver
  import jk_exc_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int SETTLE    = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic             C,
  input  logic             RESETn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_bits
);

  localparam int RETRY_W  = cnt_width(MAX_RETRY);
  localparam int SETTLE_W = cnt_width(SETTLE);
  localparam logic [RETRY_W-1:0]  RETRY_LAST  = RETRY_W'(MAX_RETRY);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  jk_state_e           state_q, state_d;
  logic [WIDTH-1:0]    tgt_q, tgt_d;
  logic [WIDTH-1:0]    j_q, j_d;
  logic [WIDTH-1:0]    k_q, k_d;
  logic [WIDTH-1:0]    err_bits_q, err_bits_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [WIDTH-1:0]    enc_tgt;
  logic [WIDTH-1:0]    enc_j;
  logic [WIDTH-1:0]    enc_k;
  logic                accept;

  // in_ready_q is low for the first cycle after reset, so no accept happens then.
  assign accept  = (state_q == ST_IDLE) && in_valid && in_ready_q;

  // On accept the encoder sees the incoming word; on a retry, the latched target.
  assign enc_tgt = (state_q == ST_IDLE) ? in_target : tgt_q;

  jk_exc_encode #(
    .WIDTH (WIDTH)
  ) u_encode (
    .tgt (enc_tgt),
    .q   (q_fb),
    .j   (enc_j),
    .k   (enc_k)
  );

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    retry_d    = retry_q;
    settle_d   = settle_q;
    err_bits_d = err_bits_q;
    j_d        = '0;
    k_d        = '0;
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tgt_d      = in_target;
          retry_d    = '0;
          j_d        = enc_j;
          k_d        = enc_k;
          err_bits_d = '0;
          busy_d     = 1'b1;
          state_d    = ST_DRIVE;
        end else begin
          in_ready_d = 1'b1;
        end
      end

      ST_DRIVE: begin
        settle_d = SETTLE_LAST;
        busy_d   = 1'b1;
        state_d  = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_q != '0) begin
          settle_d = settle_q - SETTLE_W'(1);
          busy_d   = 1'b1;
        end else if (q_fb == tgt_q) begin
          done_d     = 1'b1;
          in_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (retry_q < RETRY_LAST) begin
          // Compare precedes increment, so retry_q never exceeds RETRY_LAST.
          retry_d = retry_q + RETRY_W'(1);
          j_d     = enc_j;
          k_d     = enc_k;
          busy_d  = 1'b1;
          state_d = ST_DRIVE;
        end else begin
          err_d      = 1'b1;
          err_bits_d = q_fb ^ tgt_q;
          in_ready_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge C or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= ST_IDLE;
      tgt_q      <= '0;
      retry_q    <= '0;
      settle_q   <= '0;
      err_bits_q <= '0;
      j_q        <= '0;
      // All-ones K clears the bank while reset is held.
      k_q        <= '1;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      retry_q    <= retry_d;
      settle_q   <= settle_d;
      err_bits_q <= err_bits_d;
      j_q        <= j_d;
      k_q        <= k_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign j_out    = j_q;
  assign k_out    = k_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_bits = err_bits_q;

endmodule
